// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache with RISC-V byte/half/word access.
// Load hits return data combinationally; misses stall while the line is written back and refilled one beat at a time.
module dcache #(
    parameter int SETS        = 64,
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic                  cpu_we,
    input  logic                  cpu_re,
    input  logic [2:0]            cpu_mode,
    output logic [31:0]           cpu_rdata,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
);

    localparam int WB = $clog2(BLOCK_WORDS);
    localparam int IB = $clog2(SETS);
    localparam int WW = (WB > 0) ? WB : 1;
    localparam int TB = ADDR_WIDTH - 2 - WB - IB;
    localparam logic [WW-1:0] LAST = WW'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t          state, state_nxt;
    logic [WW-1:0]   beat;
    logic [SETS-1:0] valid, dirty;
    logic [TB-1:0]   tags [SETS];
    logic [31:0]     data [SETS][BLOCK_WORDS];

    logic [IB-1:0] idx;
    logic [WW-1:0] word;
    logic [TB-1:0] tag;
    logic          access, hit, ready, load_hit, store_hit, last_beat;
    logic [31:0]   cur_word, st_word;
    logic [7:0]    ld_b;
    logic [15:0]   ld_h;

    assign idx  = cpu_addr[2+WB +: IB];
    assign word = WW'((cpu_addr >> 2) & ADDR_WIDTH'(BLOCK_WORDS - 1));
    assign tag  = cpu_addr[ADDR_WIDTH-1 -: TB];

    assign access    = cpu_re | cpu_we;
    assign hit       = valid[idx] && (tags[idx] == tag);
    assign ready     = (state == IDLE) && hit;
    assign stall     = access && !ready;
    assign load_hit  = ready && cpu_re && !cpu_we;
    assign store_hit = ready && cpu_we;
    assign last_beat = mem_ack && (beat == LAST);

    assign cur_word = data[idx][word];
    assign ld_b     = 8'(cur_word >> {cpu_addr[1:0], 3'b000});
    assign ld_h     = cpu_addr[1] ? cur_word[31:16] : cur_word[15:0];

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [TB-1:0] t,
                                                        input logic [IB-1:0] i,
                                                        input logic [WW-1:0] b);
        return (ADDR_WIDTH'(t) << (2 + WB + IB)) | (ADDR_WIDTH'(i) << (2 + WB)) |
               (ADDR_WIDTH'(b) << 2);
    endfunction

    always_comb begin
        cpu_rdata = '0;
        if (load_hit) begin
            case (cpu_mode)
                3'b000:  cpu_rdata = {{24{ld_b[7]}}, ld_b};
                3'b001:  cpu_rdata = {{16{ld_h[15]}}, ld_h};
                3'b100:  cpu_rdata = {24'b0, ld_b};
                3'b101:  cpu_rdata = {16'b0, ld_h};
                default: cpu_rdata = cur_word;
            endcase
        end
    end

    // Only the addressed byte lanes change; the rest keep the cached word.
    always_comb begin
        st_word = cur_word;
        case (cpu_mode[1:0])
            2'b00:   st_word[{cpu_addr[1:0], 3'b000} +: 8] = cpu_wdata[7:0];
            2'b01:   st_word[{cpu_addr[1], 4'b0000} +: 16] = cpu_wdata[15:0];
            default: st_word = cpu_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (access && !hit)
                    state_nxt = (valid[idx] && dirty[idx]) ? WRITEBACK : REFILL;
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = beat_addr(tags[idx], idx, beat);
                mem_wdata = data[idx][beat];
                if (last_beat) state_nxt = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = beat_addr(tag, idx, beat);
                if (last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            beat <= '0;
        else if (state != IDLE && mem_ack)
            beat <= (beat == LAST) ? '0 : beat + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (state == REFILL && last_beat) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (store_hit) begin
            dirty[idx] <= 1'b1;
        end
    end

    // Line storage carries no reset; valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == REFILL && mem_ack) begin
                data[idx][beat] <= mem_rdata;
                if (beat == LAST) tags[idx] <= tag;
            end else if (store_hit) begin
                data[idx][word] <= st_word;
            end
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache against a word-addressed memory that returns each word's own address.
module tb_dcache;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_we, cpu_re, stall;
    logic [2:0]  cpu_mode;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic        log_we[$];
    int          lat = 0;
    int          hold = 0;
    bit          hold_arm = 1'b0;
    logic [31:0] hold_addr = 32'h0;

    dcache dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_mode(cpu_mode), .cpu_rdata(cpu_rdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial forever #5 clk = ~clk;

    // Memory: ack two cycles after a beat appears, optionally held off on one chosen read beat.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_ack = 1'b0;
                lat     = 0;
                hold    = 0;
            end else begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                    lat     = 0;
                end
                if (mem_req) begin
                    if (hold_arm && !mem_we && mem_addr == hold_addr) begin
                        hold     = 10;
                        hold_arm = 1'b0;
                    end else if (hold > 0) begin
                        hold--;
                    end else begin
                        lat++;
                        if (lat >= 2) begin
                            mem_ack   = 1'b1;
                            mem_rdata = mem_addr;
                            log_addr.push_back(mem_addr);
                            log_wdata.push_back(mem_wdata);
                            log_we.push_back(mem_we);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic re, input logic we, input logic [2:0] mode,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        cpu_re = re; cpu_we = we; cpu_mode = mode; cpu_addr = addr; cpu_wdata = wd;
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (stall && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, {31'b0, stall}, 32'h0);
    endtask

    task automatic wait_addr(input string tag, input logic [31:0] a);
        int n = 0;
        while (!(mem_req && mem_addr == a) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, {31'b0, (mem_req && mem_addr == a)}, 32'h1);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_wdata.delete();
        log_we.delete();
    endtask

    task automatic chk_reads(input string tag, input int start, input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_addr"}, log_addr[start+i], base + 32'(4 * i));
            chk({tag, "_we"}, {31'b0, log_we[start+i]}, 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; cpu_mode = 3'b010;
        cpu_addr = 32'h0; cpu_wdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        clear_log();

        // Cold load miss
        drive(1, 0, 3'b010, 32'h40, 32'h0);
        chk("cold_stall", {31'b0, stall}, 32'h1);
        chk("cold_rdata_stalled", cpu_rdata, 32'h0);
        wait_done("cold_done");
        chk("cold_rdata", cpu_rdata, 32'h40);
        chk("cold_nbeats", log_addr.size(), 32'd4);
        chk_reads("cold", 0, 32'h40);
        drive(1, 0, 3'b010, 32'h44, 32'h0);
        chk("hit44_stall", {31'b0, stall}, 32'h0);
        chk("hit44_rdata", cpu_rdata, 32'h44);

        // Byte store, then extension modes
        drive(0, 1, 3'b000, 32'h41, 32'h12345680);
        chk("sb_stall", {31'b0, stall}, 32'h0);
        chk("sb_rdata", cpu_rdata, 32'h0);
        drive(1, 0, 3'b000, 32'h41, 32'h0);
        chk("lb_rdata", cpu_rdata, 32'hFFFF_FF80);
        chk("lb_stall", {31'b0, stall}, 32'h0);
        drive(1, 0, 3'b100, 32'h41, 32'h0);
        chk("lbu_rdata", cpu_rdata, 32'h0000_0080);
        drive(1, 0, 3'b001, 32'h42, 32'h0);
        chk("lh_rdata", cpu_rdata, 32'h0000_0000);
        drive(1, 0, 3'b010, 32'h40, 32'h0);
        chk("lw_rdata", cpu_rdata, 32'h0000_8040);
        drive(0, 0, 3'b010, 32'h40, 32'h0);
        chk("noacc_stall", {31'b0, stall}, 32'h0);
        chk("noacc_rdata", cpu_rdata, 32'h0);

        // Dirty conflict eviction
        clear_log();
        drive(1, 0, 3'b010, 32'h440, 32'h0);
        chk("evd_stall", {31'b0, stall}, 32'h1);
        wait_done("evd_done");
        chk("evd_nbeats", log_addr.size(), 32'd8);
        for (int i = 0; i < 4; i++) begin
            chk("evd_wb_addr", log_addr[i], 32'h40 + 32'(4 * i));
            chk("evd_wb_we", {31'b0, log_we[i]}, 32'h1);
            chk("evd_wb_data", log_wdata[i], (i == 0) ? 32'h8040 : 32'h40 + 32'(4 * i));
        end
        chk_reads("evd_rf", 4, 32'h440);
        chk("evd_rdata", cpu_rdata, 32'h440);

        // Clean eviction with memory back-pressure on beat 1
        clear_log();
        hold_addr = 32'h844;
        hold_arm  = 1'b1;
        drive(1, 0, 3'b010, 32'h840, 32'h0);
        wait_addr("bp_reach", 32'h844);
        begin
            logic stable = 1'b1;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                #1;
                stable &= mem_req && !mem_we && stall && (mem_addr == 32'h844);
            end
            chk("bp_stable", {31'b0, stable}, 32'h1);
        end
        chk("bp_acks_held", log_addr.size(), 32'd1);
        wait_done("evc_done");
        chk("evc_nbeats", log_addr.size(), 32'd4);
        chk_reads("evc", 0, 32'h840);
        chk("evc_rdata", cpu_rdata, 32'h840);

        // Halfword store and loads
        drive(0, 1, 3'b001, 32'h846, 32'h1234BEEF);
        chk("sh_stall", {31'b0, stall}, 32'h0);
        drive(1, 0, 3'b001, 32'h846, 32'h0);
        chk("lh_hi", cpu_rdata, 32'hFFFF_BEEF);
        drive(1, 0, 3'b101, 32'h846, 32'h0);
        chk("lhu_hi", cpu_rdata, 32'h0000_BEEF);
        drive(1, 0, 3'b001, 32'h844, 32'h0);
        chk("lh_lo", cpu_rdata, 32'h0000_0844);
        drive(1, 0, 3'b010, 32'h847, 32'h0);
        chk("lw_unaligned", cpu_rdata, 32'hBEEF_0844);

        // Store miss completes once the line is present
        clear_log();
        drive(0, 1, 3'b010, 32'h204, 32'hCAFEF00D);
        chk("swm_stall", {31'b0, stall}, 32'h1);
        wait_done("swm_done");
        chk("swm_nbeats", log_addr.size(), 32'd4);
        chk_reads("swm", 0, 32'h200);
        drive(1, 0, 3'b010, 32'h204, 32'h0);
        chk("swm_lw", cpu_rdata, 32'hCAFE_F00D);
        drive(1, 0, 3'b010, 32'h208, 32'h0);
        chk("swm_lw_other", cpu_rdata, 32'h208);

        // Reset during refill beat 2
        drive(1, 0, 3'b010, 32'h100, 32'h0);
        wait_addr("rr_reach", 32'h108);
        rst = 1'b1;
        cpu_re = 1'b0;
        @(negedge clk);
        #1;
        chk("rr_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rr_stall", {31'b0, stall}, 32'h0);
        rst = 1'b0;
        clear_log();
        drive(1, 0, 3'b010, 32'h100, 32'h0);
        chk("rr_miss_again", {31'b0, stall}, 32'h1);
        wait_done("rr_done");
        chk("rr_nbeats", log_addr.size(), 32'd4);
        chk_reads("rr", 0, 32'h100);
        chk("rr_rdata", cpu_rdata, 32'h100);
        drive(1, 0, 3'b010, 32'h40, 32'h0);
        chk("rr_old_line_gone", {31'b0, stall}, 32'h1);
        drive(0, 0, 3'b010, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
